// File: rtl/approx_chk_pkg.sv
// Shared types and the golden abs-diff helper for the approximate-circuit sweeper.
package approx_chk_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  // Wide enough for any practical operand; callers narrow the result to N_OUT bits.
  localparam int DIFF_W = 16;

  function automatic logic [DIFF_W-1:0] exact_abs_diff(input logic [DIFF_W-1:0] a,
                                                       input logic [DIFF_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/abs_diff_exact.sv
// Combinational golden model: exact |a - b| of the two operand halves of a vector.
module abs_diff_exact
  import approx_chk_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) (
  input  logic [N_IN-1:0]  vec,
  output logic [N_OUT-1:0] exact
);

  assign exact = N_OUT'(exact_abs_diff(DIFF_W'(vec[N_IN/2-1:0]), DIFF_W'(vec[N_IN-1:N_IN/2])));

endmodule

// File: rtl/approx_err_sweeper.sv
// Exhaustive error sweeper for an approximate abs-diff candidate.
// Optional per-vector trace outputs are built when ERR_TRACE_EN is defined.
module approx_err_sweeper
  import approx_chk_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int N_OUT   = 2,
  parameter int ET      = 1,
  parameter int DUT_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [N_IN-1:0]       cand_in,
  input  logic [N_OUT-1:0]      cand_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_OUT-1:0]      max_err,
  output logic [N_IN:0]         viol_cnt,
  output logic [N_IN+N_OUT-1:0] sum_err,
  output logic [N_IN-1:0]       first_viol_vec
`ifdef ERR_TRACE_EN
  ,
  output logic                  trace_valid,
  output logic [N_IN-1:0]       trace_vec,
  output logic [N_OUT-1:0]      trace_err
`endif
);

  localparam int SUM_W = N_IN + N_OUT;

  function automatic logic [N_OUT-1:0] abs_err(input logic [N_OUT-1:0] x,
                                               input logic [N_OUT-1:0] y);
    return (x > y) ? (x - y) : (y - x);
  endfunction

  state_t            state, state_nxt;
  logic              go;
  logic [N_IN:0]     cnt;
  logic              vld_p0;
  logic              vld_s;
  logic [N_IN-1:0]   tag_s;
  logic              last_s;
  logic [N_OUT-1:0]  exact_s;
  logic [N_OUT-1:0]  err_s;

  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    unique case (state)
      IDLE:    if (start) begin go = 1'b1; state_nxt = DRIVE; end
      DRIVE:   if (cnt[N_IN]) state_nxt = last_s ? DONE : DRAIN;
      DRAIN:   if (last_s) state_nxt = DONE;
      DONE:    if (start) begin go = 1'b1; state_nxt = DRIVE; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: drive vector; cnt runs one ahead of cand_in and its MSB marks the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      cand_in <= '0;
      vld_p0  <= 1'b0;
    end else if (go) begin
      cnt     <= (N_IN+1)'(1);
      cand_in <= '0;
      vld_p0  <= 1'b1;
    end else if (state == DRIVE && !cnt[N_IN]) begin
      cnt     <= cnt + (N_IN+1)'(1);
      cand_in <= cnt[N_IN-1:0];
      vld_p0  <= 1'b1;
    end else begin
      vld_p0  <= 1'b0;
    end
  end

  // Tag delay line: aligns the vector tag with the candidate's latency.
  generate
    if (DUT_LAT == 0) begin : g_no_dl
      assign vld_s = vld_p0;
      assign tag_s = cand_in;
    end else begin : g_dl
      logic [DUT_LAT-1:0] vld_dl;
      logic [N_IN-1:0]    tag_dl [DUT_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_dl <= '0;
        end else begin
          vld_dl[0] <= vld_p0;
          for (int i = 1; i < DUT_LAT; i++) vld_dl[i] <= vld_dl[i-1];
        end
      end

      always_ff @(posedge clk) begin
        tag_dl[0] <= cand_in;
        for (int i = 1; i < DUT_LAT; i++) tag_dl[i] <= tag_dl[i-1];
      end

      assign vld_s = vld_dl[DUT_LAT-1];
      assign tag_s = tag_dl[DUT_LAT-1];
    end
  endgenerate

  assign last_s = vld_s && (tag_s == '1);

  abs_diff_exact #(.N_IN(N_IN), .N_OUT(N_OUT)) u_gold (
    .vec   (tag_s),
    .exact (exact_s)
  );

  assign err_s = abs_err(exact_s, cand_out);

  // Stage p1: accumulate statistics; a new sweep clears them on the start edge.
  always_ff @(posedge clk) begin
    if (rst || go) begin
      max_err        <= '0;
      viol_cnt       <= '0;
      sum_err        <= '0;
      first_viol_vec <= '0;
    end else if (vld_s) begin
      if (32'(err_s) > ET) begin
        if (viol_cnt == '0) first_viol_vec <= tag_s;
        viol_cnt <= viol_cnt + (N_IN+1)'(1);
      end
      if (err_s > max_err) max_err <= err_s;
      sum_err <= sum_err + SUM_W'(err_s);
    end
  end

  assign busy = (state == DRIVE) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (viol_cnt == '0);

`ifdef ERR_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst) trace_valid <= 1'b0;
    else     trace_valid <= vld_s;
  end

  always_ff @(posedge clk) begin
    trace_vec <= tag_s;
    trace_err <= err_s;
  end
`endif

endmodule

// File: tb/tb_approx_err_sweeper.sv
// Bench for approx_err_sweeper: combinational (DUT_LAT=0) and 2-cycle (DUT_LAT=2) instances side by side.
module tb_approx_err_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] cin0, cin2, fv0, fv2;
  logic [1:0] cout0, cout2, max0, max2;
  logic [4:0] viol0, viol2;
  logic [5:0] sum0, sum2;
  logic       busy0, done0, pass0, busy2, done2, pass2;

  logic [1:0] lut [16];
  logic [1:0] r1, r2;

  assign cout0 = lut[cin0];
  always @(posedge clk) begin
    r1 <= lut[cin2];
    r2 <= r1;
  end
  assign cout2 = r2;

`ifdef ERR_TRACE_EN
  logic       tv0, tv2;
  logic [3:0] tvec0, tvec2;
  logic [1:0] terr0, terr2;
  int         trace_cnt = 0;
  always @(posedge clk) if (tv0) trace_cnt <= trace_cnt + 1;
`endif

  approx_err_sweeper #(.N_IN(4), .N_OUT(2), .ET(1), .DUT_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .cand_in(cin0), .cand_out(cout0),
    .busy(busy0), .done(done0), .pass(pass0), .max_err(max0), .viol_cnt(viol0),
    .sum_err(sum0), .first_viol_vec(fv0)
`ifdef ERR_TRACE_EN
    , .trace_valid(tv0), .trace_vec(tvec0), .trace_err(terr0)
`endif
  );

  approx_err_sweeper #(.N_IN(4), .N_OUT(2), .ET(1), .DUT_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .cand_in(cin2), .cand_out(cout2),
    .busy(busy2), .done(done2), .pass(pass2), .max_err(max2), .viol_cnt(viol2),
    .sum_err(sum2), .first_viol_vec(fv2)
`ifdef ERR_TRACE_EN
    , .trace_valid(tv2), .trace_vec(tvec2), .trace_err(terr2)
`endif
  );

  typedef struct {
    int max_e;
    int viol;
    int sum;
    int first;
    int pass;
  } stats_t;

  typedef struct {
    int     kind;       // 0 exact, 1 tied 0, 2 exact^1, 3 random
    int     mid_start;  // cycle of an ignored start pulse, -1 none
    int     rst_at;     // cycle of mid-sweep reset, -1 none
    stats_t exp;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int exact_of(input int v);
    int a, b;
    a = v % 4;
    b = v / 4;
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic set_lut(input int kind);
    for (int v = 0; v < 16; v++) begin
      case (kind)
        0:       lut[v] = 2'(exact_of(v));
        1:       lut[v] = 2'd0;
        2:       lut[v] = 2'(exact_of(v) ^ 1);
        default: lut[v] = 2'($urandom_range(0, 3));
      endcase
    end
  endtask

  function automatic stats_t model();
    stats_t s;
    int e;
    s = '{0, 0, 0, 0, 1};
    for (int v = 0; v < 16; v++) begin
      e = exact_of(v) - int'(lut[v]);
      if (e < 0) e = -e;
      if (e > 1) begin
        if (s.viol == 0) s.first = v;
        s.viol++;
      end
      if (e > s.max_e) s.max_e = e;
      s.sum += e;
    end
    s.pass = (s.viol == 0);
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_sweep(input string nm, input int mid_start, input int rst_at, input stats_t exp);
    int  d0 = -1;
    int  d2 = -1;
    int  seq_bad = 0;
    bit  aborted = 1'b0;
    start = 1'b1;
    cyc = 0;
`ifdef ERR_TRACE_EN
    trace_cnt = 0;
`endif
    step();
    start = 1'b0;
    chk({nm, " busy@1"}, int'(busy0), 1);
    while (cyc < 40 && !aborted && !(d0 >= 0 && d2 >= 0)) begin
      if (cyc <= 16 && cin0 != 4'(cyc - 1)) seq_bad++;
      if (done0 && d0 < 0) d0 = cyc;
      if (done2 && d2 < 0) d2 = cyc;
      if (!(d0 >= 0 && d2 >= 0)) begin
        if (cyc == mid_start) start = 1'b1;
        if (cyc == rst_at) rst = 1'b1;
        step();
        start = 1'b0;
        if (rst) begin
          rst = 1'b0;
          aborted = 1'b1;
        end
      end
    end
    if (aborted) begin
      chk({nm, " rst busy"}, int'(busy0) + int'(busy2), 0);
      chk({nm, " rst done"}, int'(done0) + int'(done2), 0);
      chk({nm, " rst stats0"}, int'(max0) + int'(viol0) + int'(sum0) + int'(fv0) + int'(cin0), 0);
      chk({nm, " rst stats2"}, int'(max2) + int'(viol2) + int'(sum2) + int'(fv2) + int'(cin2), 0);
      return;
    end
    chk({nm, " done cycle lat0"}, d0, 17);
    chk({nm, " done cycle lat2"}, d2, 19);
    chk({nm, " cand_in sequence"}, seq_bad, 0);
    chk({nm, " cand_in hold"}, int'(cin0), 15);
    chk({nm, " busy at done"}, int'(busy0) + int'(busy2), 0);
    chk({nm, " max_err"}, int'(max0), exp.max_e);
    chk({nm, " viol_cnt"}, int'(viol0), exp.viol);
    chk({nm, " sum_err"}, int'(sum0), exp.sum);
    chk({nm, " first_viol"}, int'(fv0), exp.first);
    chk({nm, " pass"}, int'(pass0), exp.pass);
    chk({nm, " lat2 max_err"}, int'(max2), exp.max_e);
    chk({nm, " lat2 viol_cnt"}, int'(viol2), exp.viol);
    chk({nm, " lat2 sum_err"}, int'(sum2), exp.sum);
    chk({nm, " lat2 first_viol"}, int'(fv2), exp.first);
    chk({nm, " lat2 pass"}, int'(pass2), exp.pass);
`ifdef ERR_TRACE_EN
    chk({nm, " trace pulses"}, trace_cnt, 16);
`endif
  endtask

  vec_t tbl [7];

  initial begin
    tbl[0] = '{0, -1, -1, '{0, 0, 0, 0, 1}};
    tbl[1] = '{1, -1, -1, '{3, 6, 20, 2, 0}};
    tbl[2] = '{2, -1, -1, '{1, 0, 16, 0, 1}};
    tbl[3] = '{0, 5, -1, '{0, 0, 0, 0, 1}};
    tbl[4] = '{1, -1, -1, '{3, 6, 20, 2, 0}};
    tbl[5] = '{0, -1, 8, '{0, 0, 0, 0, 1}};
    tbl[6] = '{0, -1, -1, '{0, 0, 0, 0, 1}};

    set_lut(0);
    rst = 1'b1;
    step();
    step();
    chk("reset busy", int'(busy0) + int'(busy2), 0);
    chk("reset done", int'(done0) + int'(done2), 0);
    chk("reset pass", int'(pass0) + int'(pass2), 0);
    chk("reset stats", int'(max0) + int'(viol0) + int'(sum0) + int'(fv0) + int'(cin0), 0);

    start = 1'b1;
    step();
    chk("start with rst busy", int'(busy0), 0);
    rst = 1'b0;
    start = 1'b0;
    step();
    chk("idle after rst", int'(busy0) + int'(done0), 0);

    for (int i = 0; i < 7; i++) begin
      set_lut(tbl[i].kind);
      run_sweep($sformatf("tbl%0d", i), tbl[i].mid_start, tbl[i].rst_at, tbl[i].exp);
    end

    for (int i = 0; i < 4; i++) begin
      set_lut(3);
      run_sweep($sformatf("rnd%0d", i), -1, -1, model());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
